// File: rtl/keypad_time_entry.sv
// keypad_time_entry
//   Front end of the microwave controller. Debounces the one-hot keypad into
//   digit strokes. Shifts the strokes into a 3-digit BCD time register (M:SS).
//   On a falling edge of the start key it issues a one-cycle load pulse that
//   carries the normalised time.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   teclado      keypad, one-hot, bit k = digit k
//   comecan      start key, active-low level (falling edge starts)
//   limpan       clear key, active-low level, sampled synchronously
//   enable       downstream timer idle; keys and start are ignored when low
//   min_bcd      minutes digit
//   sec_ten_bcd  tens-of-seconds digit
//   sec_one_bcd  units-of-seconds digit
//   digit_count  digits entered since last clear/load, saturating at 3
//   key_strobe   one-cycle pulse per accepted digit
//   load         one-cycle pulse; BCD outputs hold the loaded time meanwhile
module keypad_time_entry #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] teclado,
  input  logic       comecan,
  input  logic       limpan,
  input  logic       enable,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_ten_bcd,
  output logic [3:0] sec_one_bcd,
  output logic [1:0] digit_count,
  output logic       key_strobe,
  output logic       load
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEB_PRESS = 2'd1,
    S_HELD      = 2'd2,
    S_DEB_REL   = 2'd3
  } state_t;

  // The counter value seen on the edge that completes a debounce window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_cand;
  logic [3:0]       r_min;
  logic [3:0]       r_ten;
  logic [3:0]       r_one;
  logic [1:0]       r_count;
  logic             r_key_strobe;
  logic             r_load;
  logic             r_comecan_d;

  logic       w_key_valid;
  logic [3:0] w_key_digit;
  logic       w_time_nz;
  logic       w_load_go;
  logic       w_press_done;

  assign w_key_valid = $onehot(teclado);

  always_comb begin
    w_key_digit = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (teclado[k]) w_key_digit = 4'(k);
    end
  end

  assign w_time_nz = |{r_min, r_ten, r_one};

  // Start event: registered copy high, live level low. A clear at the same
  // edge wins, so the (now zero) time is never loaded.
  assign w_load_go = r_comecan_d & ~comecan & enable & w_time_nz & limpan;

  // Last debounce sample of a stable press; r_load forces the FSM idle instead.
  assign w_press_done = (r_state == S_DEB_PRESS) && enable && !r_load &&
                        (teclado == r_cand) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cand       <= '0;
      r_min        <= 4'd0;
      r_ten        <= 4'd0;
      r_one        <= 4'd0;
      r_count      <= 2'd0;
      r_key_strobe <= 1'b0;
      r_load       <= 1'b0;
      r_comecan_d  <= 1'b1;
    end else begin
      r_comecan_d  <= comecan;
      r_load       <= w_load_go;
      // A digit discarded by clear or load produces no strobe.
      r_key_strobe <= w_press_done & limpan & ~w_load_go;

      // Key FSM
      if (r_load) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable && w_key_valid) begin
              r_cand  <= teclado;
              r_cnt   <= CNT_ONE;
              r_state <= S_DEB_PRESS;
            end
          end
          S_DEB_PRESS: begin
            if (!enable || teclado != r_cand) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_HELD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_HELD: begin
            // No auto-repeat: only a full release leaves this state.
            if (teclado == 10'd0) begin
              r_cnt   <= CNT_ONE;
              r_state <= S_DEB_REL;
            end
          end
          default: begin // S_DEB_REL
            if (teclado != 10'd0) begin
              r_state <= S_HELD;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        endcase
      end

      // Time register: clear > post-load clear > load normalise > shift
      if (!limpan || r_load) begin
        r_min   <= 4'd0;
        r_ten   <= 4'd0;
        r_one   <= 4'd0;
        r_count <= 2'd0;
      end else if (w_load_go) begin
        if (r_ten > 4'd5) begin
          r_ten <= 4'd5;
          r_one <= 4'd9;
        end
      end else if (w_press_done) begin
        r_min <= r_ten;
        r_ten <= r_one;
        r_one <= w_key_digit;
        if (r_count != 2'd3) r_count <= r_count + 2'd1;
      end
    end
  end

  assign min_bcd     = r_min;
  assign sec_ten_bcd = r_ten;
  assign sec_one_bcd = r_one;
  assign digit_count = r_count;
  assign key_strobe  = r_key_strobe;
  assign load        = r_load;

endmodule

// File: tb/tb_keypad_time_entry.sv
module tb_keypad_time_entry;

  logic       clk;
  logic       resetn;
  logic [9:0] teclado;
  logic       comecan;
  logic       limpan;
  logic       enable;
  logic [3:0] min_bcd;
  logic [3:0] sec_ten_bcd;
  logic [3:0] sec_one_bcd;
  logic [1:0] digit_count;
  logic       key_strobe;
  logic       load;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int load_cnt   = 0;

  // Reference model: the entered time as a plain decimal number 0..999.
  int m_time  = 0;
  int m_count = 0;

  keypad_time_entry #(.DEBOUNCE(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .teclado(teclado), .comecan(comecan),
    .limpan(limpan), .enable(enable), .min_bcd(min_bcd),
    .sec_ten_bcd(sec_ten_bcd), .sec_one_bcd(sec_one_bcd),
    .digit_count(digit_count), .key_strobe(key_strobe), .load(load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe) strobe_cnt++;
    if (load) load_cnt++;
  end

  function automatic void m_key(input int d);
    m_time = (m_time * 10 + d) % 1000;
    if (m_count < 3) m_count++;
  endfunction

  function automatic void m_clear();
    m_time  = 0;
    m_count = 0;
  endfunction

  function automatic logic [11:0] exp_digits();
    return {4'(m_time / 100), 4'((m_time / 10) % 10), 4'(m_time % 10)};
  endfunction

  // Time presented during the load pulse: seconds above 59 become 59.
  function automatic logic [11:0] exp_loaded();
    int t;
    int o;
    t = (m_time / 10) % 10;
    o = m_time % 10;
    if (t > 5) begin
      t = 5;
      o = 9;
    end
    return {4'(m_time / 100), 4'(t), 4'(o)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] pat, input int hold, input int gap);
    teclado = pat;
    repeat (hold) cycle();
    teclado = 10'd0;
    repeat (gap) cycle();
  endtask

  task automatic clear_pulse();
    limpan = 1'b0;
    cycle();
    limpan = 1'b1;
    m_clear();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== 12'h000) begin
      failures++; $display("FAIL reset_digits: got %h want 000", {min_bcd, sec_ten_bcd, sec_one_bcd});
    end
    checks++;
    if (digit_count !== 2'd0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", digit_count);
    end
    checks++;
    if (key_strobe !== 1'b0 || load !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: got strobe=%b load=%b want 0 0", key_strobe, load);
    end
    resetn = 1'b1;
    cycle();
    m_clear();
  endtask

  task automatic test_keys_100();
    strobe_cnt = 0;
    press(10'd1 << 1, 5, 9); m_key(1);
    press(10'd1 << 0, 5, 9); m_key(0);
    press(10'd1 << 0, 5, 9); m_key(0);
    $display("keys 1,0,0 -> %0d%0d%0d count=%0d strobes=%0d", min_bcd, sec_ten_bcd, sec_one_bcd, digit_count, strobe_cnt);
    checks++;
    if (strobe_cnt !== 3) begin
      failures++; $display("FAIL keys100_strobes: got %0d want 3", strobe_cnt);
    end
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits()) begin
      failures++; $display("FAIL keys100_digits: got %h want %h", {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_digits());
    end
    checks++;
    if (digit_count !== 2'(m_count)) begin
      failures++; $display("FAIL keys100_count: got %0d want %0d", digit_count, m_count);
    end
  endtask

  task automatic test_load_099();
    clear_pulse();
    press(10'd1 << 0, 5, 9); m_key(0);
    press(10'd1 << 9, 5, 9); m_key(9);
    press(10'd1 << 9, 5, 9); m_key(9);
    load_cnt = 0;
    comecan = 1'b0;
    cycle();
    $display("start at 0:99 -> load=%b out=%0d%0d%0d", load, min_bcd, sec_ten_bcd, sec_one_bcd);
    checks++;
    if (load !== 1'b1) begin
      failures++; $display("FAIL load099_pulse: got %b want 1", load);
    end
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_loaded()) begin
      failures++; $display("FAIL load099_norm: got %h want %h", {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_loaded());
    end
    cycle();
    m_clear();
    checks++;
    if ({load, min_bcd, sec_ten_bcd, sec_one_bcd, digit_count} !== 15'd0) begin
      failures++; $display("FAIL load099_after: got load=%b digits=%h count=%0d want all 0", load, {min_bcd, sec_ten_bcd, sec_one_bcd}, digit_count);
    end
    // Holding comecan low must not trigger again.
    repeat (5) cycle();
    comecan = 1'b1;
    cycle();
    checks++;
    if (load_cnt !== 1) begin
      failures++; $display("FAIL load099_single: got %0d loads want 1", load_cnt);
    end
  endtask

  task automatic test_bounce();
    strobe_cnt = 0;
    press(10'd1 << 7, 3, 9);
    checks++;
    if (strobe_cnt !== 0 || {min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits()) begin
      failures++; $display("FAIL bounce_short: got strobes=%0d digits=%h want 0 and %h", strobe_cnt, {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_digits());
    end
    press(10'd1 << 7, 200, 9); m_key(7);
    $display("key 7 long hold -> strobes=%0d digits=%0d%0d%0d", strobe_cnt, min_bcd, sec_ten_bcd, sec_one_bcd);
    checks++;
    if (strobe_cnt !== 1) begin
      failures++; $display("FAIL bounce_long_strobes: got %0d want 1", strobe_cnt);
    end
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits()) begin
      failures++; $display("FAIL bounce_long_digits: got %h want %h", {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_digits());
    end
  endtask

  task automatic test_multihot();
    logic [9:0] pat;
    pat = 10'b0000100001;
    strobe_cnt = 0;
    press(pat, 10, 9);
    checks++;
    if (strobe_cnt !== 0 || {min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits()) begin
      failures++; $display("FAIL multihot: got strobes=%0d digits=%h want 0 and %h", strobe_cnt, {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_digits());
    end
    clear_pulse();
    load_cnt = 0;
    comecan = 1'b0;
    repeat (3) cycle();
    comecan = 1'b1;
    cycle();
    $display("start at 0:00 -> loads=%0d", load_cnt);
    checks++;
    if (load_cnt !== 0) begin
      failures++; $display("FAIL zero_time_load: got %0d loads want 0", load_cnt);
    end
  endtask

  task automatic test_clear();
    press(10'd1 << 2, 5, 9); m_key(2);
    press(10'd1 << 3, 5, 9); m_key(3);
    press(10'd1 << 4, 5, 9); m_key(4);
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits()) begin
      failures++; $display("FAIL clear_entry: got %h want %h", {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_digits());
    end
    clear_pulse();
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd, digit_count} !== 14'd0) begin
      failures++; $display("FAIL clear_digits: got %h count=%0d want 0", {min_bcd, sec_ten_bcd, sec_one_bcd}, digit_count);
    end
    // Clear on the exact edge where key 6 completes its debounce.
    teclado = 10'd1 << 6;
    repeat (3) cycle();
    limpan = 1'b0;
    cycle();
    limpan = 1'b1;
    teclado = 10'd0;
    repeat (9) cycle();
    $display("strobe with clear -> digits=%0d%0d%0d count=%0d", min_bcd, sec_ten_bcd, sec_one_bcd, digit_count);
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd, digit_count} !== 14'd0) begin
      failures++; $display("FAIL clear_coincident: got %h count=%0d want 0", {min_bcd, sec_ten_bcd, sec_one_bcd}, digit_count);
    end
  endtask

  task automatic test_enable_reset();
    press(10'd1 << 5, 5, 9); m_key(5);
    load_cnt = 0;
    enable = 1'b0;
    comecan = 1'b0;
    repeat (3) cycle();
    comecan = 1'b1;
    cycle();
    enable = 1'b1;
    checks++;
    if (load_cnt !== 0 || {min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits()) begin
      failures++; $display("FAIL disabled_start: got loads=%0d digits=%h want 0 and %h", load_cnt, {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_digits());
    end
    // Key pressed while disabled is ignored.
    strobe_cnt = 0;
    enable = 1'b0;
    press(10'd1 << 8, 6, 9);
    enable = 1'b1;
    checks++;
    if (strobe_cnt !== 0) begin
      failures++; $display("FAIL disabled_key: got %0d strobes want 0", strobe_cnt);
    end
    // Asynchronous reset in the middle of a press debounce.
    strobe_cnt = 0;
    teclado = 10'd1 << 3;
    repeat (2) cycle();
    #3;
    resetn = 1'b0;
    #1;
    m_clear();
    checks++;
    if ({min_bcd, sec_ten_bcd, sec_one_bcd, digit_count, key_strobe, load} !== 16'd0) begin
      failures++; $display("FAIL async_reset: got digits=%h count=%0d strobe=%b load=%b want all 0", {min_bcd, sec_ten_bcd, sec_one_bcd}, digit_count, key_strobe, load);
    end
    teclado = 10'd0;
    cycle();
    resetn = 1'b1;
    repeat (10) cycle();
    checks++;
    if (strobe_cnt !== 0 || {min_bcd, sec_ten_bcd, sec_one_bcd} !== 12'h000) begin
      failures++; $display("FAIL post_reset: got strobes=%0d digits=%h want 0 and 000", strobe_cnt, {min_bcd, sec_ten_bcd, sec_one_bcd});
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      int exp_strobes;
      clear_pulse();
      strobe_cnt  = 0;
      exp_strobes = 0;
      n = $urandom_range(1, 5);
      for (int p = 0; p < n; p++) begin
        int d;
        int hold;
        int gap;
        logic [9:0] pat;
        logic multi;
        d    = $urandom_range(0, 9);
        hold = $urandom_range(1, 7);
        gap  = $urandom_range(5, 8);
        multi = ($urandom_range(0, 5) == 0);
        pat = 10'd1 << d;
        if (multi) pat = pat | (10'd1 << ((d + 1 + $urandom_range(0, 8)) % 10));
        $display("rand press pat=%b hold=%0d gap=%0d", pat, hold, gap);
        press(pat, hold, gap);
        if (!multi && hold >= 4) begin
          m_key(d);
          exp_strobes++;
        end
      end
      checks++;
      if (strobe_cnt !== exp_strobes) begin
        failures++; $display("FAIL rand_strobes[%0d]: got %0d want %0d", r, strobe_cnt, exp_strobes);
      end
      checks++;
      if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_digits() || digit_count !== 2'(m_count)) begin
        failures++; $display("FAIL rand_digits[%0d]: got %h count=%0d want %h count=%0d", r, {min_bcd, sec_ten_bcd, sec_one_bcd}, digit_count, exp_digits(), m_count);
      end
      comecan = 1'b0;
      cycle();
      $display("rand start time=%0d load=%b out=%0d%0d%0d", m_time, load, min_bcd, sec_ten_bcd, sec_one_bcd);
      checks++;
      if (load !== (m_time != 0)) begin
        failures++; $display("FAIL rand_load[%0d]: got %b want %b", r, load, (m_time != 0));
      end
      if (m_time != 0) begin
        checks++;
        if ({min_bcd, sec_ten_bcd, sec_one_bcd} !== exp_loaded()) begin
          failures++; $display("FAIL rand_loaded[%0d]: got %h want %h", r, {min_bcd, sec_ten_bcd, sec_one_bcd}, exp_loaded());
        end
      end
      cycle();
      comecan = 1'b1;
      cycle();
    end
  endtask

  initial begin
    resetn  = 1'b0;
    teclado = 10'd0;
    comecan = 1'b1;
    limpan  = 1'b1;
    enable  = 1'b1;
    test_reset();
    test_keys_100();
    test_load_099();
    test_bounce();
    test_multihot();
    test_clear();
    test_enable_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
- Upstream stage of the microwave controller.
- Converts the raw one-hot keypad `teclado` into debounced digit strokes.
- Shifts the digits into a 3-digit BCD cooking-time register (M:SS).
- On the active-low start key `comecan`, issues a one-cycle `load` pulse with the normalised time to the downstream countdown/magnetron controller.
- Also handles the active-low clear key `limpan`.

Parameters:
- DEBOUNCE, 4, consecutive identical samples required to accept a key press or a release (legal range ≥2).
- CNT_W, 3, width of the debounce counter; must hold DEBOUNCE.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- teclado  in  10  keypad, one-hot; bit k high = digit k pressed
- comecan  in  1  start key, active-low level
- limpan  in  1  clear key, active-low level, sampled synchronously
- enable  in  1  high while the downstream timer is idle; keys and start are ignored when low
- min_bcd  out  4  minutes digit
- sec_ten_bcd  out  4  tens-of-seconds digit
- sec_one_bcd  out  4  units-of-seconds digit
- digit_count  out  2  digits entered since last clear/load, saturates at 3
- key_strobe  out  1  one-cycle pulse per accepted digit
- load  out  1  one-cycle pulse; the BCD outputs hold the loaded time in that cycle

Behaviour:
- Reset (resetn=0, async):
  - all digits 0, digit_count 0, key_strobe 0, load 0.
  - FSM goes to IDLE; debounce counter 0; comecan edge register 1.
- Key validity: `teclado` is valid when exactly one bit is set. Encoding is bit index → BCD 0..9. Zero or multi-hot is "no key".
- FSM states: IDLE, DEB_PRESS, HELD, DEB_REL.
  - IDLE: a valid key with enable=1 → latch candidate, counter=1, go to DEB_PRESS.
  - DEB_PRESS:
    - sample equal to candidate → counter+1.
    - on reaching DEBOUNCE → go to HELD and assert key_strobe for exactly that one cycle, registered with the digit shift.
    - any different sample (including multi-hot or zero) → back to IDLE with no strobe.
  - HELD: teclado==0 → counter=1, go to DEB_REL. Any other value stays in HELD, so there is no auto-repeat.
  - DEB_REL: zero for DEBOUNCE consecutive cycles → IDLE. Any nonzero sample → back to HELD.
- Digit shift on key_strobe: min←sec_ten, sec_ten←sec_one, sec_one←new digit. The old minutes digit is discarded. digit_count increments, saturating at 3.
- Start:
  - comecan is edge-detected via a registered copy; a 1→0 transition is the start event.
  - load=1 in the cycle after the edge, only if enable=1 and the time is nonzero. Otherwise the event is dropped.
  - Normalisation in the load cycle: if sec_ten>5, the seconds are clamped to 5,9. Minutes are unchanged.
  - Cycle after load: digits and digit_count clear to 0. Any in-progress key FSM returns to IDLE.
- Clear: limpan=0 at a clock edge → digits and digit_count 0. The FSM is not reset, so a held key does not re-strobe.
- Priority at one edge: resetn > limpan > load/post-load clear > key_strobe shift. A strobe coinciding with clear is discarded.
- enable falling mid-debounce: FSM returns to IDLE and no strobe is issued.
- comecan held low does not retrigger. A new load needs a release followed by a fresh falling edge.

Test Plan:
- Keys 1,0,0, each held 5 cycles and released 9 cycles (DEBOUNCE=4) → exactly 3 key_strobe pulses; outputs 1,0,0; digit_count=3.
- Keys 0,9,9, then comecan 1→0 with enable=1 → load pulse with outputs 0,5,9. Next cycle all 0, digit_count 0.
- Key 7 held 3 cycles then released (bounce) → no strobe, digits unchanged. Key held 200 cycles → single strobe.
- teclado=10'b0000100001 for 10 cycles → no strobe. Then comecan falls with time 0:00 → no load.
- Enter 2,3,4; assert limpan=0 for 1 cycle → all digits 0. Also a strobe coincident with limpan → digits stay 0.
- Enter 5; comecan falls with enable=0 → no load. Then resetn pulsed low asynchronously mid-DEB_PRESS → all outputs 0 immediately, no strobe afterward.
